// File: rtl/float_to_float_signed_pipe_pkg.sv
// Shared float definitions: classification, status flags and exponent helpers
// for the Float -> FloatSigned converter.
package FloatDef;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NORM
    } FloatClass;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic invalid;
    } StatusFlags;

    function automatic int getExpBias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

    function automatic int getSignedExpMax(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

    function automatic int getSignedExpMin(input int expW);
        return -(1 << (expW - 1));
    endfunction

endpackage

// File: rtl/float_to_float_signed_pipe_if.sv
// Handshaked operand/result bundles: IEEE-style Float in, FloatSigned out.
interface FloatIf #(
    parameter int EXP  = 8,
    parameter int FRAC = 23
);
    logic            sign;
    logic [EXP-1:0]  exponent;
    logic [FRAC-1:0] fraction;
    logic            inValid;
    logic            inReady;

    modport master (output sign, exponent, fraction, inValid, input inReady);
    modport slave  (input sign, exponent, fraction, inValid, output inReady);
endinterface

interface FloatSignedIf #(
    parameter int SIGNED_EXP  = 3,
    parameter int SIGNED_FRAC = 8
);
    logic                   sign;
    logic                   isInf;
    logic                   isZero;
    logic [SIGNED_EXP-1:0]  exp;
    logic [SIGNED_FRAC-1:0] frac;
    logic                   outValid;
    logic                   outReady;
    logic                   overflow;
    logic                   underflow;
    logic                   inexact;
    logic                   invalid;

    modport master (output sign, isInf, isZero, exp, frac, outValid,
                    overflow, underflow, inexact, invalid, input outReady);
    modport slave  (input sign, isInf, isZero, exp, frac, outValid,
                    overflow, underflow, inexact, invalid, output outReady);
endinterface

// File: rtl/float_to_float_signed_pipe_rne.sv
// Round-to-nearest-even of an IN_W-bit fraction down to OUT_W bits; carry
// flags a round-up that overflowed the kept field (fracOut is then zero).
module RoundNearestEven #(
    parameter int IN_W  = 23,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  fracIn,
    output logic [OUT_W-1:0] fracOut,
    output logic             carry,
    output logic             inexact
);
    localparam int DROP = IN_W - OUT_W;

    logic           guard;
    logic           sticky;
    logic           roundUp;
    logic [OUT_W:0] sum;

    assign guard = fracIn[DROP-1];

    generate
        if (DROP > 1) begin : gSticky
            assign sticky = |fracIn[DROP-2:0];
        end else begin : gNoSticky
            assign sticky = 1'b0;
        end
    endgenerate

    // Ties go up only when the kept LSB is odd.
    assign roundUp        = guard & (sticky | fracIn[DROP]);
    assign sum            = {1'b0, fracIn[IN_W-1:DROP]} + {{OUT_W{1'b0}}, roundUp};
    assign {carry, fracOut} = sum;
    assign inexact        = guard | sticky;
endmodule

// File: rtl/float_to_float_signed_pipe.sv
// Two-stage Float -> FloatSigned converter: S1 classifies and unbiases,
// S2 rounds, clamps to the signed exponent range and holds the result.
module float_to_float_signed_pipe
    import FloatDef::*;
#(
    parameter int EXP         = 8,
    parameter int FRAC        = 23,
    parameter int SIGNED_EXP  = 3,
    parameter int SIGNED_FRAC = 8
) (
    input  logic          clock,
    input  logic          resetn,
    FloatIf.slave         in,
    FloatSignedIf.master  out
);
    localparam logic        [EXP:0] BIAS  = (EXP+1)'(getExpBias(EXP));
    localparam logic signed [EXP:0] E_MAX = (EXP+1)'(getSignedExpMax(SIGNED_EXP));
    localparam logic signed [EXP:0] E_MIN = (EXP+1)'(getSignedExpMin(SIGNED_EXP));

    logic                   s1Valid, s1Sign;
    FloatClass              s1Class, inClass;
    logic signed [EXP:0]    s1E;
    logic [FRAC-1:0]        s1Frac;

    logic                   s2Valid, s2Adv;
    logic                   s2Sign, s2Inf, s2Zero;
    logic [SIGNED_EXP-1:0]  s2Exp;
    logic [SIGNED_FRAC-1:0] s2Frac;
    StatusFlags             s2Flags;

    // Ready is gated by resetn so nothing is accepted while reset is held.
    assign s2Adv      = !s2Valid || out.outReady;
    assign in.inReady = resetn && (!s1Valid || s2Adv);

    always_comb begin
        inClass = CLS_NORM;
        if (in.exponent == '0)
            inClass = CLS_ZERO;
        else if (&in.exponent)
            inClass = (in.fraction == '0) ? CLS_INF : CLS_NAN;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1Valid <= 1'b0;
            s1Sign  <= 1'b0;
            s1Class <= CLS_ZERO;
            s1E     <= '0;
            s1Frac  <= '0;
        end else if (in.inReady) begin
            s1Valid <= in.inValid;
            if (in.inValid) begin
                s1Sign  <= in.sign;
                s1Class <= inClass;
                s1E     <= {1'b0, in.exponent} - BIAS;
                s1Frac  <= in.fraction;
            end
        end
    end

    logic [SIGNED_FRAC-1:0] rndFrac;
    logic                   rndCarry, rndInexact;
    logic signed [EXP:0]    eRnd;

    RoundNearestEven #(.IN_W(FRAC), .OUT_W(SIGNED_FRAC)) uRound (
        .fracIn  (s1Frac),
        .fracOut (rndFrac),
        .carry   (rndCarry),
        .inexact (rndInexact)
    );

    // EXP+1 bits hold the largest normal exponent plus a rounding carry.
    assign eRnd = s1E + (EXP+1)'(rndCarry);

    logic                   nSign, nInf, nZero;
    logic [SIGNED_EXP-1:0]  nExp;
    logic [SIGNED_FRAC-1:0] nFrac;
    StatusFlags             nFlags;

    always_comb begin
        nSign  = s1Sign;
        nInf   = 1'b0;
        nZero  = 1'b0;
        nExp   = '0;
        nFrac  = '0;
        nFlags = '0;
        case (s1Class)
            CLS_ZERO: begin
                nZero            = 1'b1;
                nFlags.underflow = |s1Frac;
                nFlags.inexact   = |s1Frac;
            end
            CLS_INF, CLS_NAN: begin
                nSign          = 1'b0;
                nInf           = 1'b1;
                nFlags.invalid = (s1Class == CLS_NAN);
            end
            default: begin
                if (eRnd > E_MAX) begin
                    nSign           = 1'b0;
                    nInf            = 1'b1;
                    nFlags.overflow = 1'b1;
                    nFlags.inexact  = 1'b1;
                end else if (eRnd < E_MIN) begin
                    nZero            = 1'b1;
                    nFlags.underflow = 1'b1;
                    nFlags.inexact   = 1'b1;
                end else begin
                    nExp           = eRnd[SIGNED_EXP-1:0];
                    nFrac          = rndFrac;
                    nFlags.inexact = rndInexact;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s2Valid <= 1'b0;
            s2Sign  <= 1'b0;
            s2Inf   <= 1'b0;
            s2Zero  <= 1'b1;
            s2Exp   <= '0;
            s2Frac  <= '0;
            s2Flags <= '0;
        end else if (s2Adv) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                s2Sign  <= nSign;
                s2Inf   <= nInf;
                s2Zero  <= nZero;
                s2Exp   <= nExp;
                s2Frac  <= nFrac;
                s2Flags <= nFlags;
            end
        end
    end

    assign out.outValid  = s2Valid;
    assign out.sign      = s2Sign;
    assign out.isInf     = s2Inf;
    assign out.isZero    = s2Zero;
    assign out.exp       = s2Exp;
    assign out.frac      = s2Frac;
    assign out.overflow  = s2Flags.overflow;
    assign out.underflow = s2Flags.underflow;
    assign out.inexact   = s2Flags.inexact;
    assign out.invalid   = s2Flags.invalid;
endmodule

// File: tb/tb_float_to_float_signed_pipe.sv
// Bench for float_to_float_signed_pipe at EXP=8, FRAC=23, SIGNED_EXP=3, SIGNED_FRAC=8.
module tb_float_to_float_signed_pipe;

    logic clock;
    logic resetn;
    int   cyc;
    int   total;
    int   bad;

    FloatIf       #(.EXP(8), .FRAC(23))             tbIn();
    FloatSignedIf #(.SIGNED_EXP(3), .SIGNED_FRAC(8)) tbOut();

    float_to_float_signed_pipe #(
        .EXP(8), .FRAC(23), .SIGNED_EXP(3), .SIGNED_FRAC(8)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .in     (tbIn),
        .out    (tbOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Result packed as {sign, isInf, isZero, exp[2:0], frac[7:0], ov, un, ix, iv}.
    logic [17:0] dutVal;
    assign dutVal = {tbOut.sign, tbOut.isInf, tbOut.isZero, tbOut.exp, tbOut.frac,
                     tbOut.overflow, tbOut.underflow, tbOut.inexact, tbOut.invalid};

    localparam int F_OV = 8, F_UN = 4, F_IX = 2, F_IV = 1;

    function automatic logic [17:0] pk(input int s, input int inf, input int z,
                                       input int e, input int f, input int fl);
        return {s[0], inf[0], z[0], e[2:0], f[7:0], fl[3:0]};
    endfunction

    // Reference: value-level conversion with integer rounding arithmetic.
    function automatic logic [17:0] model(input logic [31:0] x);
        int s, ex, f, e, q, r, fl;
        s  = int'(x[31]);
        ex = int'(x[30:23]);
        f  = int'(x[22:0]);
        if (ex == 0)
            return pk(s, 0, 1, 0, 0, (f != 0) ? (F_UN | F_IX) : 0);
        if (ex == 255)
            return pk(0, 1, 0, 0, 0, (f != 0) ? F_IV : 0);
        e  = ex - 127;
        q  = f / 32768;
        r  = f % 32768;
        fl = (r != 0) ? F_IX : 0;
        if (r > 16384 || (r == 16384 && (q % 2) == 1)) q = q + 1;
        if (q == 256) begin
            q = 0;
            e = e + 1;
        end
        if (e > 3)  return pk(0, 1, 0, 0, 0, F_OV | F_IX);
        if (e < -4) return pk(s, 0, 1, 0, 0, F_UN | F_IX);
        return pk(s, 0, 0, e, q, fl);
    endfunction

    function automatic logic [31:0] randFloat();
        logic [22:0] f;
        logic [7:0]  ex;
        f  = 23'($urandom);
        ex = 8'(120 + $urandom_range(14));
        case ($urandom_range(3))
            0: return $urandom;
            1: begin
                ex = $urandom_range(1) ? 8'h00 : 8'hFF;
                if ($urandom_range(1) == 0) f = '0;
            end
            default: if ($urandom_range(3) == 0) f[14:0] = 15'h4000;
        endcase
        return {1'($urandom_range(1)), ex, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Scoreboard: expected result, acceptance cycle and latency-check flag per transfer.
    logic [17:0] expQ[$];
    int          accQ[$];
    bit          latQ[$];
    logic [17:0] curExp;
    bit          curLat;
    logic [17:0] held;
    bit          holding;

    always @(negedge clock) begin
        logic [17:0] e;
        int          a;
        bit          l;
        if (!resetn) begin
            expQ.delete();
            accQ.delete();
            latQ.delete();
            holding = 1'b0;
        end else begin
            if (tbOut.outValid && !tbOut.outReady) begin
                if (holding) chk("hold_stable", 32'(dutVal), 32'(held));
                holding = 1'b1;
                held    = dutVal;
            end else if (tbOut.outValid) begin
                if (holding) chk("hold_stable", 32'(dutVal), 32'(held));
                holding = 1'b0;
                if (expQ.size() == 0) begin
                    chk("unexpected_out", 32'(dutVal), 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    a = accQ.pop_front();
                    l = latQ.pop_front();
                    chk("out_value", 32'(dutVal), 32'(e));
                    if (l) chk("latency", 32'(cyc - a), 32'd2);
                end
            end else begin
                holding = 1'b0;
            end
            if (tbIn.inValid && tbIn.inReady) begin
                expQ.push_back(curExp);
                accQ.push_back(cyc);
                latQ.push_back(curLat);
            end
        end
    end

    task automatic setIn(input logic [31:0] x);
        {tbIn.sign, tbIn.exponent, tbIn.fraction} = x;
    endtask

    // Called and returns at posedge+1; holds the operand until accepted.
    task automatic send(input logic [31:0] x, input logic [17:0] want);
        int n;
        n = 0;
        setIn(x);
        curExp      = want;
        tbIn.inValid = 1'b1;
        forever begin
            @(negedge clock);
            if (tbIn.inReady) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clock); #1;
        tbIn.inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        tbOut.outReady = 1'b1;
        tbIn.inValid   = 1'b0;
        while (expQ.size() != 0 && n < 30) begin
            @(posedge clock); #1;
            n++;
        end
        chk("drain_empty", 32'(expQ.size()), 32'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [31:0] in;
        logic [17:0] want;
    } vec_t;

    vec_t        tbl[19];
    logic [31:0] ops[6];

    initial begin
        total = 0;
        bad   = 0;
        tbl[0]  = '{32'h3F800000, pk(0, 0, 0, 0, 'h00, 0)};
        tbl[1]  = '{32'h3FC00000, pk(0, 0, 0, 0, 'h80, 0)};
        tbl[2]  = '{32'h3F804000, pk(0, 0, 0, 0, 'h00, F_IX)};
        tbl[3]  = '{32'h3F80C000, pk(0, 0, 0, 0, 'h02, F_IX)};
        tbl[4]  = '{32'h3FFFFFFF, pk(0, 0, 0, 1, 'h00, F_IX)};
        tbl[5]  = '{32'h41800000, pk(0, 1, 0, 0, 'h00, F_OV | F_IX)};
        tbl[6]  = '{32'h3D000000, pk(0, 0, 1, 0, 'h00, F_UN | F_IX)};
        tbl[7]  = '{32'h7FC00000, pk(0, 1, 0, 0, 'h00, F_IV)};
        tbl[8]  = '{32'h41000000, pk(0, 0, 0, 3, 'h00, 0)};
        tbl[9]  = '{32'h3D800000, pk(0, 0, 0, 4, 'h00, 0)};
        tbl[10] = '{32'hBF800000, pk(1, 0, 0, 0, 'h00, 0)};
        tbl[11] = '{32'h80000001, pk(1, 0, 1, 0, 'h00, F_UN | F_IX)};
        tbl[12] = '{32'h00000000, pk(0, 0, 1, 0, 'h00, 0)};
        tbl[13] = '{32'hFF800000, pk(0, 1, 0, 0, 'h00, 0)};
        tbl[14] = '{32'h417FFFFF, pk(0, 1, 0, 0, 'h00, F_OV | F_IX)};
        tbl[15] = '{32'h40FFFFFF, pk(0, 0, 0, 3, 'h00, F_IX)};
        tbl[16] = '{32'hBD7FFFFF, pk(1, 0, 0, 4, 'h00, F_IX)};
        tbl[17] = '{32'h3F808000, pk(0, 0, 0, 0, 'h01, 0)};
        tbl[18] = '{32'h3F814000, pk(0, 0, 0, 0, 'h02, F_IX)};
        ops = '{32'h3F800000, 32'h40000000, 32'hC0400000,
                32'h3E800000, 32'h41000000, 32'h3F804000};

        resetn         = 1'b0;
        tbIn.inValid   = 1'b0;
        tbOut.outReady = 1'b1;
        setIn('0);
        curExp  = '0;
        curLat  = 1'b0;
        holding = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outValid", 32'(tbOut.outValid), 32'd0);
        chk("reset_inReady",  32'(tbIn.inReady),   32'd0);
        chk("reset_out",      32'(dutVal),         32'(pk(0, 0, 1, 0, 0, 0)));
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("release_inReady", 32'(tbIn.inReady), 32'd1);
        @(posedge clock); #1;

        // Directed vectors, back-to-back, exact latency
        curLat = 1'b1;
        for (int i = 0; i < 19; i++) send(tbl[i].in, tbl[i].want);
        drain();

        // Stall mid-stream: outReady low for cycles 2..5
        curLat = 1'b0;
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 40 && idx < 6; c++) begin
                tbOut.outReady = !(c >= 2 && c <= 5);
                setIn(ops[idx]);
                curExp       = model(ops[idx]);
                tbIn.inValid = 1'b1;
                @(negedge clock);
                if (c >= 2 && c <= 5) chk("stall_inReady", 32'(tbIn.inReady), 32'd0);
                if (c == 5) chk("stall_buffered", 32'(idx), 32'd2);
                if (tbIn.inReady) idx++;
                @(posedge clock); #1;
            end
            tbIn.inValid = 1'b0;
            chk("stall_all_sent", 32'(idx), 32'd6);
        end
        drain();

        // Randomized traffic with random backpressure
        begin
            int sent;
            logic [31:0] x;
            sent = 0;
            for (int c = 0; c < 600 && sent < 200; c++) begin
                tbOut.outReady = ($urandom_range(3) != 0);
                if ($urandom_range(3) != 0) begin
                    x = randFloat();
                    setIn(x);
                    curExp       = model(x);
                    tbIn.inValid = 1'b1;
                end else begin
                    tbIn.inValid = 1'b0;
                end
                @(negedge clock);
                if (tbIn.inValid && tbIn.inReady) sent++;
                @(posedge clock); #1;
            end
            tbIn.inValid = 1'b0;
        end
        drain();

        // Reset with both stages full
        tbOut.outReady = 1'b0;
        send(32'h3FC00000, model(32'h3FC00000));
        send(32'h40400000, model(32'h40400000));
        @(negedge clock);
        chk("full_inReady",  32'(tbIn.inReady),   32'd0);
        chk("full_outValid", 32'(tbOut.outValid), 32'd1);
        @(posedge clock); #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn         = 1'b1;
        tbOut.outReady = 1'b1;
        @(negedge clock);
        chk("midreset_outValid", 32'(tbOut.outValid), 32'd0);
        chk("midreset_inReady",  32'(tbIn.inReady),   32'd1);
        chk("midreset_out",      32'(dutVal),         32'(pk(0, 0, 1, 0, 0, 0)));
        @(posedge clock); #1;
        curLat = 1'b1;
        send(32'hBFC00000, pk(1, 0, 0, 0, 'h80, 0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
